// File: rtl/rv32i_if_stage.sv
// rv32i_if_stage: instruction fetch stage.
// Owns the fetch PC and issues one word request at a time to instruction
// memory (req/gnt/rvalid). It hands {pc, instr} to decode through a
// valid/ready handshake. Execute can redirect it at any time, and a response
// that is still in flight when the redirect arrives is dropped.
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   imem_req_o/addr_o     fetch request and word-aligned byte address
//   imem_gnt_i            request accepted this cycle
//   imem_rvalid_i/rdata_i response valid and instruction word
//   redirect_i/pc_i       control-flow redirect from execute
//   id_ready_i            decode accepts the payload
//   if_valid_o/payload_o  {pc, instr} toward decode, zero when not valid

package rv32i_if_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_payload_t;
endpackage

module rv32i_if_stage
  import rv32i_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  output logic           imem_req_o,
  output logic [31:0]    imem_addr_o,
  input  logic           imem_gnt_i,
  input  logic           imem_rvalid_i,
  input  logic [31:0]    imem_rdata_i,
  input  logic           redirect_i,
  input  logic [31:0]    redirect_pc_i,
  input  logic           id_ready_i,
  output logic           if_valid_o,
  output if_id_payload_t if_payload_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;

  state_t      r_state, w_state_d;
  logic [31:0] r_fetch_pc, w_fetch_pc_d;
  logic [31:0] r_issued_pc, w_issued_pc_d;
  logic [31:0] r_out_pc, w_out_pc_d;
  logic [31:0] r_out_instr, w_out_instr_d;
  logic        r_drop, w_drop_d;
  logic        w_req, w_valid;

  // Redirect targets are forced word aligned; the low bits are discarded.
  logic w_unused_rpc;
  assign w_unused_rpc = ^redirect_pc_i[1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_REQ;
      r_fetch_pc  <= RESET_PC;
      r_issued_pc <= RESET_PC;
      r_out_pc    <= '0;
      r_out_instr <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_fetch_pc  <= w_fetch_pc_d;
      r_issued_pc <= w_issued_pc_d;
      r_out_pc    <= w_out_pc_d;
      r_out_instr <= w_out_instr_d;
      r_drop      <= w_drop_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_fetch_pc_d  = r_fetch_pc;
    w_issued_pc_d = r_issued_pc;
    w_out_pc_d    = r_out_pc;
    w_out_instr_d = r_out_instr;
    w_drop_d      = r_drop;
    w_req         = 1'b0;
    w_valid       = 1'b0;

    case (r_state)
      S_REQ: begin
        w_req = !redirect_i;
        if (w_req && imem_gnt_i) begin
          w_issued_pc_d = r_fetch_pc;
          w_fetch_pc_d  = r_fetch_pc + 32'd4;
          w_state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (r_drop) begin
            w_drop_d  = 1'b0;
            w_state_d = S_REQ;
          end else begin
            w_out_pc_d    = r_issued_pc;
            w_out_instr_d = imem_rdata_i;
            w_state_d     = S_OUT;
          end
        end
      end
      S_OUT: begin
        w_valid = 1'b1;
        if (id_ready_i && !redirect_i) begin
          // Back-to-back: the next request goes out while decode takes this one.
          w_req = 1'b1;
          if (imem_gnt_i) begin
            w_issued_pc_d = r_fetch_pc;
            w_fetch_pc_d  = r_fetch_pc + 32'd4;
            w_state_d     = S_WAIT;
          end else begin
            w_state_d = S_REQ;
          end
        end
      end
      default: w_state_d = S_REQ;
    endcase

    // A redirect overrides everything decided above.
    if (redirect_i) begin
      w_req         = 1'b0;
      w_valid       = 1'b0;
      w_fetch_pc_d  = {redirect_pc_i[31:2], 2'b00};
      w_issued_pc_d = r_issued_pc;
      w_out_pc_d    = r_out_pc;
      w_out_instr_d = r_out_instr;
      // A response that is still outstanding has to be swallowed when it lands.
      if (r_state == S_WAIT && !imem_rvalid_i) begin
        w_state_d = S_WAIT;
        w_drop_d  = 1'b1;
      end else begin
        w_state_d = S_REQ;
        w_drop_d  = 1'b0;
      end
    end
  end

  // While reset is held the state register sits in REQ, so gate the outputs here.
  assign imem_req_o   = w_req & !rst_i;
  assign imem_addr_o  = {r_fetch_pc[31:2], 2'b00};
  assign if_valid_o   = w_valid & !rst_i;
  assign if_payload_o = if_valid_o ? '{pc: r_out_pc, instr: r_out_instr} : '0;

endmodule

// File: tb/tb_rv32i_if_stage.sv
module tb_rv32i_if_stage;
  import rv32i_if_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           imem_req_o;
  logic [31:0]    imem_addr_o;
  logic           imem_gnt_i;
  logic           imem_rvalid_i;
  logic [31:0]    imem_rdata_i;
  logic           redirect_i;
  logic [31:0]    redirect_pc_i;
  logic           id_ready_i;
  logic           if_valid_o;
  if_id_payload_t if_payload_o;

  rv32i_if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_ready_i(id_ready_i), .if_valid_o(if_valid_o), .if_payload_o(if_payload_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [31:0] I0   = 32'h0000_0093;
  localparam logic [31:0] I1   = 32'h0010_0113;
  localparam logic [31:0] I2   = 32'h0020_0193;
  localparam logic [31:0] I100 = 32'h1000_0213;
  localparam logic [31:0] I200 = 32'h2000_0293;
  localparam logic [31:0] IFC  = 32'hFFC0_0313;
  localparam logic [31:0] I40  = 32'h0400_0393;
  localparam logic [31:0] I0B  = 32'h0B00_0413;

  typedef struct {
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc, e_ins;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tv[30];

  function automatic vec_t mk(logic gnt, logic rv, logic [31:0] rdata, logic redir,
                              logic [31:0] rpc, logic rdy, logic e_req, logic [31:0] e_addr,
                              logic e_vld, logic [31:0] e_pc, logic [31:0] e_ins);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc; v.e_ins = e_ins;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic gnt, logic rv, logic [31:0] rdata, logic redir,
                       logic [31:0] rpc, logic rdy);
    imem_gnt_i = gnt; imem_rvalid_i = rv; imem_rdata_i = rdata;
    redirect_i = redir; redirect_pc_i = rpc; id_ready_i = rdy;
  endtask

  task automatic expect_out(string tag, logic req, logic [31:0] addr, logic vld,
                            logic [31:0] pc, logic [31:0] ins);
    chk({tag, " req"}, 32'(imem_req_o), 32'(req));
    chk({tag, " addr"}, imem_addr_o, addr);
    chk({tag, " valid"}, 32'(if_valid_o), 32'(vld));
    chk({tag, " pc"}, if_payload_o.pc, pc);
    chk({tag, " instr"}, if_payload_o.instr, ins);
  endtask

  initial begin
    tv[0]  = mk(1,0,0,0,0,1,                       1,32'h0,1'b0,0,0);
    tv[1]  = mk(0,1,I0,0,0,1,                      0,32'h4,1'b0,0,0);
    tv[2]  = mk(1,0,0,0,0,1,                       1,32'h4,1'b1,32'h0,I0);
    tv[3]  = mk(0,1,I1,0,0,1,                      0,32'h8,1'b0,0,0);
    for (int i = 4; i <= 8; i++)
      tv[i] = mk(0,0,0,0,0,0,                      0,32'h8,1'b1,32'h4,I1);
    tv[9]  = mk(1,0,0,0,0,1,                       1,32'h8,1'b1,32'h4,I1);
    tv[10] = mk(0,1,I2,0,0,1,                      0,32'hC,1'b0,0,0);
    tv[11] = mk(1,0,0,0,0,1,                       1,32'hC,1'b1,32'h8,I2);
    tv[12] = mk(0,0,0,1,32'h100,1,                 0,32'h10,1'b0,0,0);
    tv[13] = mk(0,1,32'hDEAD_BEEF,0,0,1,           0,32'h100,1'b0,0,0);
    tv[14] = mk(1,0,0,0,0,1,                       1,32'h100,1'b0,0,0);
    tv[15] = mk(0,1,I100,0,0,1,                    0,32'h104,1'b0,0,0);
    tv[16] = mk(1,0,0,0,0,1,                       1,32'h104,1'b1,32'h100,I100);
    tv[17] = mk(0,1,32'h0BAD_0BAD,1,32'h203,1,     0,32'h108,1'b0,0,0);
    tv[18] = mk(0,0,0,0,0,1,                       1,32'h200,1'b0,0,0);
    tv[19] = mk(1,0,0,0,0,1,                       1,32'h200,1'b0,0,0);
    tv[20] = mk(0,1,I200,0,0,1,                    0,32'h204,1'b0,0,0);
    tv[21] = mk(0,0,0,0,0,0,                       0,32'h204,1'b1,32'h200,I200);
    tv[22] = mk(0,0,0,1,32'hFFFF_FFFC,0,           0,32'h204,1'b0,0,0);
    tv[23] = mk(1,0,0,0,0,1,                       1,32'hFFFF_FFFC,1'b0,0,0);
    tv[24] = mk(0,1,IFC,0,0,1,                     0,32'h0,1'b0,0,0);
    tv[25] = mk(0,0,0,0,0,1,                       1,32'h0,1'b1,32'hFFFF_FFFC,IFC);
    tv[26] = mk(0,0,0,0,0,1,                       1,32'h0,1'b0,0,0);
    tv[27] = mk(0,1,32'h1234_5678,0,0,1,           1,32'h0,1'b0,0,0);
    tv[28] = mk(0,0,0,1,32'h40,1,                  0,32'h0,1'b0,0,0);
    tv[29] = mk(0,0,0,0,0,1,                       1,32'h40,1'b0,0,0);

    // Reset: inputs that would otherwise request are active during reset.
    rst_i = 1'b1;
    drive(1, 0, 0, 0, 0, 1);
    repeat (2) @(negedge clk_i);
    #1 expect_out("reset", 0, 32'h0, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 30; i++) begin
      drive(tv[i].gnt, tv[i].rv, tv[i].rdata, tv[i].redir, tv[i].rpc, tv[i].rdy);
      #1 expect_out($sformatf("vec%0d", i), tv[i].e_req, tv[i].e_addr, tv[i].e_vld,
                    tv[i].e_pc, tv[i].e_ins);
      @(negedge clk_i);
    end

    // Fetch 0x40 into OUT, hand it off with a grant, then reset mid-WAIT.
    drive(1, 0, 0, 0, 0, 1);
    #1 expect_out("s_req40", 1, 32'h40, 0, 0, 0);
    @(negedge clk_i);
    drive(0, 1, I40, 0, 0, 1);
    #1 expect_out("s_rv40", 0, 32'h44, 0, 0, 0);
    @(negedge clk_i);
    drive(1, 0, 0, 0, 0, 1);
    #1 expect_out("s_out40", 1, 32'h44, 1, 32'h40, I40);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 1);
    #1 expect_out("s_wait44", 0, 32'h48, 0, 0, 0);
    #2 rst_i = 1'b1;
    #1 expect_out("async_rst", 0, 32'h0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    #1 expect_out("rst_held", 0, 32'h0, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    // Late response for the abandoned fetch arrives right after release.
    drive(0, 1, 32'hBADD_CAFE, 0, 0, 1);
    #1 expect_out("late_rv", 1, 32'h0, 0, 0, 0);
    @(negedge clk_i);
    drive(1, 0, 0, 0, 0, 1);
    #1 expect_out("post_rst_req", 1, 32'h0, 0, 0, 0);
    @(negedge clk_i);
    drive(0, 1, I0B, 0, 0, 0);
    #1 expect_out("post_rst_rv", 0, 32'h4, 0, 0, 0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0);
    #1 expect_out("post_rst_out", 0, 32'h4, 1, 32'h0, I0B);
    // Reset while a payload is held must drop valid immediately.
    #2 rst_i = 1'b1;
    #1 expect_out("rst_in_out", 0, 32'h0, 0, 0, 0);
    @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
